// File: rtl/blast_pkg.sv
// Shared types and default widths for the BLAST seed-scan sequencer.
package blast_pkg;

    // Default field widths of a hit record.
    localparam int SCORE_W = 6;
    localparam int LOC_W   = 9;
    localparam int WORD_W  = 16;
    localparam int OFF_W   = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        WAIT_DB,
        WAIT,
        EVAL,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/blast_hit_reg.sv
// Hit output register: captures one hit record and holds it stable until
// the consumer accepts it with hit_ready.
module blast_hit_reg #(
    parameter int SCORE_W = blast_pkg::SCORE_W,
    parameter int LOC_W   = blast_pkg::LOC_W,
    parameter int WORD_W  = blast_pkg::WORD_W,
    parameter int OFF_W   = blast_pkg::OFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic [SCORE_W-1:0] score,
    input  logic [LOC_W-1:0]   loc,
    input  logic [WORD_W-1:0]  word,
    input  logic [OFF_W-1:0]   off,
    input  logic               hit_ready,
    output logic               hit_valid,
    output logic [SCORE_W-1:0] hit_score,
    output logic [LOC_W-1:0]   hit_qloc,
    output logic [WORD_W-1:0]  hit_word,
    output logic [OFF_W-1:0]   hit_off
);

    // Load a new record on capture, drop valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_valid <= 1'b0;
            hit_score <= '0;
            hit_qloc  <= '0;
            hit_word  <= '0;
            hit_off   <= '0;
        end else if (capture) begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, so ordering inside the block cannot race.
            hit_valid <= 1'b1;
            hit_score <= score;
            hit_qloc  <= loc;
            hit_word  <= word;
            hit_off   <= off;
        end else if (hit_valid && hit_ready) begin
            hit_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/blast_scan_ctrl.sv
// BLAST seed-scan sequencer: loads the query, streams database words into the
// shift register, steps it one nucleotide at a time, waits out the comparator
// latency and reports hits through a valid/ready hit record interface.
module blast_scan_ctrl #(
    parameter int DATA_W  = 512,
    parameter int SHIFTS  = 246,
    parameter int CMP_LAT = 2,
    parameter int SCORE_W = blast_pkg::SCORE_W,
    parameter int LOC_W   = blast_pkg::LOC_W,
    parameter int WORD_W  = blast_pkg::WORD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SCORE_W-1:0]          thresh,
    input  logic                        query_valid,
    output logic                        query_ready,
    output logic                        qry_load,
    input  logic                        db_valid,
    input  logic                        db_last,
    output logic                        db_ready,
    output logic                        sr_load,
    output logic                        sr_shift,
    input  logic [SCORE_W-1:0]          arr_score,
    input  logic [LOC_W-1:0]            arr_loc,
    output logic                        hit_valid,
    input  logic                        hit_ready,
    output logic [SCORE_W-1:0]          hit_score,
    output logic [LOC_W-1:0]            hit_qloc,
    output logic [WORD_W-1:0]           hit_word,
    output logic [blast_pkg::OFF_W-1:0] hit_off,
    output logic                        busy,
    output logic                        done
);
    import blast_pkg::*;

    // A word cannot be shifted further than the nucleotides it holds.
    localparam int NT_PER_WORD = DATA_W / 2;
    localparam int LAST_OFF    = ((SHIFTS < NT_PER_WORD) ? SHIFTS : NT_PER_WORD) - 1;
    localparam int LAT_W       = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LAST_OFF);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CMP_LAT - 1);

    state_t               state;
    logic [SCORE_W-1:0]   thr;
    logic [WORD_W-1:0]    word;
    logic [OFF_W-1:0]     off;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 last;
    logic                 hit_now;
    logic                 advance;

    assign qry_load = query_valid & query_ready;
    assign sr_load  = db_valid & db_ready;

    // Hit decision in EVAL, and the advance condition shared by EVAL and EMIT.
    assign hit_now = (state == EVAL) && (thr != '0) && (arr_score >= thr);
    assign advance = ((state == EVAL) && !hit_now) ||
                     ((state == EMIT) && hit_valid && hit_ready);

    // Sequencer FSM with counters and registered handshake/strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            thr         <= '0;
            word        <= '0;
            off         <= '0;
            lat_cnt     <= '0;
            last        <= 1'b0;
            query_ready <= 1'b0;
            db_ready    <= 1'b0;
            sr_shift    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            sr_shift <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        thr         <= thresh;
                        word        <= '0;
                        query_ready <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD_Q;
                    end
                end
                LOAD_Q: begin
                    if (query_valid) begin
                        query_ready <= 1'b0;
                        db_ready    <= 1'b1;
                        state       <= WAIT_DB;
                    end
                end
                WAIT_DB: begin
                    if (db_valid) begin
                        db_ready <= 1'b0;
                        last     <= db_last;
                        off      <= '0;
                        lat_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                EVAL, EMIT: begin
                    if (hit_now) begin
                        state <= EMIT;
                    end else if (advance) begin
                        if (off < OFF_LAST) begin
                            sr_shift <= 1'b1;
                            off      <= off + OFF_W'(1);
                            lat_cnt  <= '0;
                            state    <= WAIT;
                        end else if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            if (word != '1) begin
                                word <= word + WORD_W'(1);
                            end
                            db_ready <= 1'b1;
                            state    <= WAIT_DB;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    blast_hit_reg #(
        .SCORE_W (SCORE_W),
        .LOC_W   (LOC_W),
        .WORD_W  (WORD_W),
        .OFF_W   (OFF_W)
    ) u_hit_reg (
        .clk       (clk),
        .rst       (rst),
        .capture   (hit_now),
        .score     (arr_score),
        .loc       (arr_loc),
        .word      (word),
        .off       (off),
        .hit_ready (hit_ready),
        .hit_valid (hit_valid),
        .hit_score (hit_score),
        .hit_qloc  (hit_qloc),
        .hit_word  (hit_word),
        .hit_off   (hit_off)
    );

endmodule

// File: tb/tb_blast_scan_ctrl.sv
// Scoreboard bench for blast_scan_ctrl: a comparator-array model feeds scores
// from per-(word, offset) tables, a reference model lists every expected hit,
// and a monitor checks hit records, strobes and timing as the DUT emits them.
module tb_blast_scan_ctrl;

    localparam int SHIFTS   = 4;
    localparam int CMP_LAT  = 2;
    localparam int SCORE_W  = 6;
    localparam int LOC_W    = 9;
    localparam int WORD_W   = 16;
    localparam int MAXW     = 6;
    localparam int WORD_CYC = 1 + SHIFTS * (CMP_LAT + 1);

    typedef struct packed {
        logic [SCORE_W-1:0] score;
        logic [LOC_W-1:0]   loc;
        logic [WORD_W-1:0]  word;
        logic [7:0]         off;
    } hit_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [SCORE_W-1:0] thresh = '0;
    logic               query_valid = 1'b0;
    logic               query_ready, qry_load;
    logic               db_valid = 1'b0;
    logic               db_last = 1'b0;
    logic               db_ready, sr_load, sr_shift;
    logic [SCORE_W-1:0] arr_score;
    logic [LOC_W-1:0]   arr_loc;
    logic               hit_valid;
    logic               hit_ready = 1'b0;
    logic [SCORE_W-1:0] hit_score;
    logic [LOC_W-1:0]   hit_qloc;
    logic [WORD_W-1:0]  hit_word;
    logic [7:0]         hit_off;
    logic               busy, done;

    blast_scan_ctrl #(
        .SHIFTS  (SHIFTS),
        .CMP_LAT (CMP_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .thresh      (thresh),
        .query_valid (query_valid),
        .query_ready (query_ready),
        .qry_load    (qry_load),
        .db_valid    (db_valid),
        .db_last     (db_last),
        .db_ready    (db_ready),
        .sr_load     (sr_load),
        .sr_shift    (sr_shift),
        .arr_score   (arr_score),
        .arr_loc     (arr_loc),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_score   (hit_score),
        .hit_qloc    (hit_qloc),
        .hit_word    (hit_word),
        .hit_off     (hit_off),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- comparator array model ----------------
    logic [SCORE_W-1:0] score_tab [MAXW][SHIFTS];
    logic [LOC_W-1:0]   loc_tab   [MAXW][SHIFTS];
    int cur_w, cur_o, n_loaded;

    assign arr_score = score_tab[cur_w][cur_o];
    assign arr_loc   = loc_tab[cur_w][cur_o];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_w    <= 0;
            cur_o    <= 0;
            n_loaded <= 0;
        end else begin
            if (start && !busy) n_loaded <= 0;
            if (sr_load) begin
                cur_w    <= (n_loaded < MAXW - 1) ? n_loaded : MAXW - 1;
                n_loaded <= n_loaded + 1;
                cur_o    <= 0;
            end else if (sr_shift && cur_o < SHIFTS - 1) begin
                cur_o <= cur_o + 1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    hit_t exp_q[$];
    hit_t cur_rec, prev_rec;
    logic prev_hv = 1'b0, prev_hr = 1'b0;
    bit   exp_no_hits = 1'b0;
    int   cyc = 0, last_load_cyc = 0;
    int   cnt_load = 0, cnt_shift = 0, cnt_done = 0, cnt_qload = 0;

    assign cur_rec = {hit_score, hit_qloc, hit_word, hit_off};

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (sr_load) begin
                cnt_load++;
                last_load_cyc = cyc;
            end
            if (sr_shift) cnt_shift++;
            if (qry_load) cnt_qload++;
            if (sr_load || sr_shift) check("load_shift_excl", 64'(sr_load & sr_shift), 0);
            if (hit_valid) check("no_shift_in_emit", 64'(sr_shift), 0);
            if (prev_hv && hit_valid && !prev_hr) check("hit_hold", 64'(cur_rec), 64'(prev_rec));
            if (prev_hv && prev_hr) begin
                check("hit_drop", 64'(hit_valid), 0);
                if (prev_rec.off < SHIFTS - 1) check("resume_shift", 64'(sr_shift), 1);
            end
            if (hit_valid && hit_ready) begin
                if (exp_q.size() == 0) check("hit_unexpected", 64'(exp_q.size()), 1);
                else check("hit_rec", 64'(cur_rec), 64'(exp_q.pop_front()));
            end
            if (done) begin
                cnt_done++;
                if (exp_no_hits) check("done_latency", 64'(cyc - last_load_cyc), 64'(WORD_CYC));
            end
        end
        prev_hv  = hit_valid;
        prev_hr  = hit_ready;
        prev_rec = cur_rec;
    end

    // ---------------- stimulus ----------------
    task automatic fill(input int max_score);
        for (int w = 0; w < MAXW; w++)
            for (int o = 0; o < SHIFTS; o++) begin
                score_tab[w][o] = SCORE_W'($urandom_range(0, max_score));
                loc_tab[w][o]   = LOC_W'($urandom);
            end
    endtask

    task automatic run_scan(input int n, input logic [SCORE_W-1:0] th, input bit bp);
        int  sent, stall, k;
        bit  got_done;
        hit_t r;
        exp_q.delete();
        exp_no_hits = 1'b1;
        for (int w = 0; w < n; w++)
            for (int o = 0; o < SHIFTS; o++)
                if (th != 0 && score_tab[w][o] >= th) begin
                    r = {score_tab[w][o], loc_tab[w][o], WORD_W'(w), 8'(o)};
                    exp_q.push_back(r);
                    exp_no_hits = 1'b0;
                end
        cnt_load = 0; cnt_shift = 0; cnt_done = 0; cnt_qload = 0;

        @(posedge clk); #1;
        start = 1'b1; thresh = th;
        @(posedge clk); #1;
        start = 1'b0; thresh = SCORE_W'($urandom);

        sent = 0; stall = 0; k = 0; got_done = 1'b0;
        while (k < 3000 && !got_done) begin
            @(negedge clk);
            if (sr_load) sent++;
            if (hit_valid) stall++; else stall = 0;
            if (done) got_done = 1'b1;
            @(posedge clk); #1;
            query_valid = 1'($urandom_range(0, 1));
            db_valid    = ($urandom_range(0, 3) != 0);
            db_last     = db_valid ? (sent == n - 1) : 1'($urandom_range(0, 1));
            hit_ready   = bp ? (stall >= 5) : ($urandom_range(0, 2) != 0);
            start       = (k == 8);   // busy by now: must be ignored
            if (start) thresh = SCORE_W'($urandom);
            k++;
        end
        start = 1'b0; query_valid = 1'b0; db_valid = 1'b0; hit_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("scan_done_seen", 64'(got_done), 1);
        check("done_count", 64'(cnt_done), 1);
        check("sr_load_count", 64'(cnt_load), 64'(n));
        check("sr_shift_count", 64'(cnt_shift), 64'(n * (SHIFTS - 1)));
        check("qry_load_count", 64'(cnt_qload), 1);
        check("hits_left", 64'(exp_q.size()), 0);
        check("idle_after_scan", 64'(busy), 0);
    endtask

    initial begin
        int found;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({query_ready, qry_load, db_ready, sr_load, sr_shift, hit_valid, busy, done}), 0);
        check("reset_hit_rec", 64'(cur_rec), 0);
        @(posedge clk); #1 rst = 1'b1;

        // single word, no hits: score 5 below threshold 10
        fill(5);
        for (int o = 0; o < SHIFTS; o++) score_tab[0][o] = 6'd5;
        run_scan(1, 6'd10, 1'b0);

        // hit exactly at threshold
        fill(9);
        score_tab[0][2] = 6'd10; loc_tab[0][2] = 9'd37;
        run_scan(1, 6'd10, 1'b0);

        // backpressure: consumer holds hit_ready low 5 cycles per hit
        fill(39);
        score_tab[0][1] = 6'd50; score_tab[0][3] = 6'd40;
        run_scan(1, 6'd40, 1'b1);

        // three words, single hit at word 2 offset 0
        fill(29);
        score_tab[2][0] = 6'd45;
        run_scan(3, 6'd30, 1'b0);

        // threshold zero disables hits even at max score
        for (int w = 0; w < MAXW; w++)
            for (int o = 0; o < SHIFTS; o++) score_tab[w][o] = 6'd63;
        run_scan(2, 6'd0, 1'b0);

        // reset in the middle of a scan
        fill(63);
        cnt_done = 0;
        @(posedge clk); #1;
        start = 1'b1; thresh = 6'd0;
        @(posedge clk); #1;
        start = 1'b0; query_valid = 1'b1; db_valid = 1'b1; db_last = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (sr_shift) found = 1;
        end
        check("reset_test_reached_wait", 64'(found), 1);
        rst = 1'b0;
        #1;
        check("midscan_reset_outputs",
              64'({query_ready, qry_load, db_ready, sr_load, sr_shift, hit_valid, busy, done}), 0);
        query_valid = 1'b0; db_valid = 1'b0; db_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(cnt_done), 0);
        check("idle_after_reset", 64'(busy), 0);

        // randomized scans with random stalls
        for (int s = 0; s < 8; s++) begin
            fill(63);
            run_scan($urandom_range(1, 5),
                     ($urandom_range(0, 4) == 0) ? 6'd0 : SCORE_W'($urandom_range(30, 63)),
                     1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blast_scan_ctrl.md
Name: blast_scan_ctrl

Overview:
Sequencer for the BLAST seed-scan datapath. It loads the query register, streams database words into the 2-bit-per-shift database shift register, and steps the shift register one nucleotide at a time. After each step it waits out the comparator-array latency, samples the array's best score and location, and emits a hit record whenever the score meets a programmable threshold. It sits between the host/DMA streams and the comparator array, replacing free-running counters with explicit handshakes and backpressure.

Parameters:
DATA_W, 512, query/database word width in bits (2 bits per nucleotide)
SHIFTS, 246, shift positions evaluated per database word (offset 0..SHIFTS-1)
CMP_LAT, 2, comparator array + max-reduction latency in cycles (>=1)
SCORE_W, 6, score width
LOC_W, 9, query location width
WORD_W, 16, database word counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin a scan (ignored unless IDLE)
thresh  in  SCORE_W  hit threshold, sampled on accepted start; 0 = no hits reported
query_valid  in  1  query word available
query_ready  out  1  high in LOAD_Q only
qry_load  out  1  capture strobe to query register (= query_valid & query_ready)
db_valid  in  1  database word available
db_last  in  1  qualifies final database word
db_ready  out  1  high in WAIT_DB only
sr_load  out  1  parallel-load strobe to shift register (= db_valid & db_ready)
sr_shift  out  1  one-position shift strobe
arr_score  in  SCORE_W  best score from comparator array
arr_loc  in  LOC_W  query location of best score
hit_valid  out  1  hit record valid
hit_ready  in  1  hit consumer ready
hit_score  out  SCORE_W  captured score
hit_qloc  out  LOC_W  captured query location
hit_word  out  WORD_W  database word index (0-based)
hit_off  out  8  shift offset within word
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on scan completion

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; word counter, offset, latency counter, thresh register, last flag cleared.
- IDLE: start=1 -> latch thresh, word=0, go LOAD_Q.
- LOAD_Q: query_ready=1; on query_valid, qry_load pulses, go WAIT_DB.
- WAIT_DB: db_ready=1; on db_valid, sr_load pulses, latch db_last, offset=0, lat_cnt=0, go WAIT.
- WAIT: stays exactly CMP_LAT cycles, then EVAL.
- EVAL (1 cycle): if thresh!=0 and arr_score>=thresh -> register score/loc/word/offset into hit_* outputs, hit_valid=1, go EMIT. Else go ADVANCE action below.
- EMIT: hold hit_valid and hit_* stable until hit_ready; on handshake, hit_valid drops next cycle and the ADVANCE action is taken in that cycle. Scanning stalls while EMIT waits (backpressure).
- ADVANCE action: if offset<SHIFTS-1: sr_shift=1 for one cycle, offset++, lat_cnt=0, go WAIT. Else if last flag set: go DONE. Else word++ (saturates at all-ones, no wrap), go WAIT_DB.
- DONE: done=1 for one cycle, go IDLE.
- No-hit timing per offset: CMP_LAT+1 cycles; per word (no hits, no stall): 1 + SHIFTS*(CMP_LAT+1) cycles.
- Boundaries: score==thresh counts as hit; start while busy ignored; db_valid outside WAIT_DB ignored (no sr_load); db_last without a preceding word impossible (only sampled with accepted word); reset mid-scan aborts immediately, no done pulse; sr_load and sr_shift never high in the same cycle.

Decomposition:
- Package blast_pkg: state enum (IDLE, LOAD_Q, WAIT_DB, WAIT, EVAL, EMIT, DONE), SCORE_W/LOC_W constants, hit record field widths.
- One sub-module natural: blast_hit_reg (hit output register with valid/ready hold logic). FSM and counters stay in top.

Test Plan:
- Reset mid-scan: rst low during WAIT -> all outputs 0 same cycle, busy=0, no done pulse.
- Single word, no hits (SHIFTS=4, CMP_LAT=2, thresh=10, arr_score=5): db_last=1 -> exactly 3 sr_shift pulses, done 1+4*3=13 cycles after sr_load cycle, hit_valid never high.
- Hit at threshold: thresh=10, arr_score=10 at offset 2, arr_loc=37 -> one hit {score 10, qloc 37, word 0, off 2}.
- Backpressure: hit_ready low 5 cycles -> hit_* stable, no sr_shift during stall; scan resumes the cycle after handshake.
- Multi-word: 3 words, db_last on third, hit at word 2 offset 0 -> hit_word=2; db_ready high only in WAIT_DB; done once.
- thresh=0 with arr_score=63 -> no hits; start asserted while busy -> ignored.
